status_sender: RTL and testbench

// - FPGA->host framer on the proto245 TX FIFO path (counterpart of receiver). On send_req, reads NUM_WORDS

---
 rtl/status_sender.sv | 178 +++++++++++++++++
 tb/tb_status_sender.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_sender.sv
// Status frame sender: reads NUM_WORDS words from a sync-read store and writes SOF, LEN, payload
// (LSB byte first) and an optional checksum byte into the TX FIFO. Define STATUS_CHECKSUM_EN for the checksum byte.
//
// state | meaning
// IDLE  | waiting for send_req
// SOF   | emit start-of-frame byte
// LEN   | emit payload byte count
// FETCH | word_rd pulse for word idx
// LOAD  | capture word_data into shift_reg
// BYTE  | emit byte k of shift_reg
// CSUM  | emit running XOR checksum (STATUS_CHECKSUM_EN only)
module status_sender #(
   parameter int                NUM_WORDS = 32,
   parameter int                WORD_W    = 32,
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] SOF       = 8'hA5,
   parameter int                ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              send_req,
   output logic              busy,
   output logic              done,
   output logic [7:0]        dropped_cnt,
   output logic              word_rd,
   output logic [ADDR_W-1:0] word_addr,
   input  logic [WORD_W-1:0] word_data,
   input  logic              txfifo_full,
   output logic              txfifo_wr,
   output logic [DATA_W-1:0] txfifo_data
);

   localparam int BPW = WORD_W / DATA_W;
   localparam int K_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [DATA_W-1:0] LEN_BYTE = DATA_W'(NUM_WORDS * BPW);
   localparam logic [K_W-1:0]    K_LAST   = K_W'(BPW - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_WORDS - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SOF   = 3'd1;
   localparam logic [2:0] ST_LEN   = 3'd2;
   localparam logic [2:0] ST_FETCH = 3'd3;
   localparam logic [2:0] ST_LOAD  = 3'd4;
   localparam logic [2:0] ST_BYTE  = 3'd5;
`ifdef STATUS_CHECKSUM_EN
   localparam logic [2:0] ST_CSUM  = 3'd6;
`endif

   generate
      if (NUM_WORDS * WORD_W / 8 > 255) begin : g_len_chk
         $error("status_sender: frame payload exceeds 255 bytes");
      end
      if (WORD_W % DATA_W != 0) begin : g_width_chk
         $error("status_sender: WORD_W must be a multiple of DATA_W");
      end
   endgenerate

   logic [2:0]        state;
   logic [ADDR_W-1:0] idx;
   logic [K_W-1:0]    k;
   logic [WORD_W-1:0] shift_reg;
   logic              emit;
   logic [DATA_W-1:0] byte_out;
   logic              last_payload_wr;
   logic              final_wr;

`ifdef STATUS_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   always_comb begin
      emit     = 1'b0;
      byte_out = '0;
      case (state)
         ST_SOF: begin
            emit     = 1'b1;
            byte_out = SOF;
         end
         ST_LEN: begin
            emit     = 1'b1;
            byte_out = LEN_BYTE;
         end
         ST_BYTE: begin
            emit     = 1'b1;
            byte_out = shift_reg[k*DATA_W +: DATA_W];
         end
`ifdef STATUS_CHECKSUM_EN
         ST_CSUM: begin
            emit     = 1'b1;
            byte_out = checksum;
         end
`endif
         default: ;
      endcase
   end

   // Same-cycle gating: a byte is only consumed when the FIFO is not full.
   assign txfifo_wr   = emit & ~txfifo_full;
   assign txfifo_data = byte_out;
   assign busy        = (state != ST_IDLE);
   assign word_rd     = (state == ST_FETCH);
   assign word_addr   = idx;

   assign last_payload_wr = txfifo_wr && (state == ST_BYTE) && (k == K_LAST) && (idx == IDX_LAST);
`ifdef STATUS_CHECKSUM_EN
   assign final_wr = txfifo_wr && (state == ST_CSUM);
`else
   assign final_wr = last_payload_wr;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         k           <= '0;
         shift_reg   <= '0;
         done        <= 1'b0;
         dropped_cnt <= '0;
      end else begin
         done <= final_wr;
         if (send_req && (state != ST_IDLE) && (dropped_cnt != 8'hFF))
            dropped_cnt <= dropped_cnt + 8'd1;
         case (state)
            ST_IDLE: begin
               if (send_req) begin
                  state <= ST_SOF;
                  idx   <= '0;
                  k     <= '0;
               end
            end
            ST_SOF: if (txfifo_wr) state <= ST_LEN;
            ST_LEN: if (txfifo_wr) state <= ST_FETCH;
            ST_FETCH: state <= ST_LOAD;
            ST_LOAD: begin
               shift_reg <= word_data;
               k         <= '0;
               state     <= ST_BYTE;
            end
            ST_BYTE: begin
               if (txfifo_wr) begin
                  if (k == K_LAST) begin
                     k <= '0;
                     if (last_payload_wr) begin
`ifdef STATUS_CHECKSUM_EN
                        state <= ST_CSUM;
`else
                        state <= ST_IDLE;
`endif
                     end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_FETCH;
                     end
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
`ifdef STATUS_CHECKSUM_EN
            ST_CSUM: if (txfifo_wr) state <= ST_IDLE;
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef STATUS_CHECKSUM_EN
   // Covers LEN and payload bytes only; SOF is excluded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         checksum <= '0;
      else if (state == ST_IDLE && send_req)
         checksum <= '0;
      else if (txfifo_wr && (state == ST_LEN || state == ST_BYTE))
         checksum <= checksum ^ byte_out;
   end
`endif

endmodule

// File: tb/tb_status_sender.sv
// Self-checking bench for status_sender (NUM_WORDS=2): directed frames, backpressure,
// dropped requests, mid-frame reset, back-to-back and random-full frames against a frame model.
module tb_status_sender;

   localparam int NW = 2;
`ifdef STATUS_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        send_req = 1'b0;
   logic        busy;
   logic        done;
   logic [7:0]  dropped_cnt;
   logic        word_rd;
   logic [0:0]  word_addr;
   logic [31:0] word_data = '0;
   logic        txfifo_full = 1'b0;
   logic        txfifo_wr;
   logic [7:0]  txfifo_data;

   logic [31:0] mem [NW];
   logic [7:0]  cap_q [$];
   logic [7:0]  exp_q [$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          wr_full_viol = 0;

   status_sender #(.NUM_WORDS(NW)) dut (
      .clk(clk), .rst_n(rst_n), .send_req(send_req), .busy(busy), .done(done),
      .dropped_cnt(dropped_cnt), .word_rd(word_rd), .word_addr(word_addr),
      .word_data(word_data), .txfifo_full(txfifo_full), .txfifo_wr(txfifo_wr),
      .txfifo_data(txfifo_data)
   );

   always #5 clk = ~clk;

   // Sync-read store and FIFO sink
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (word_rd) word_data <= mem[word_addr];
      if (txfifo_wr) cap_q.push_back(txfifo_data);
      if (txfifo_wr && txfifo_full) wr_full_viol <= wr_full_viol + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Frame model: SOF, byte count, each word LSB first, optional XOR of LEN and payload
   task automatic build_exp();
      logic [7:0] cs;
      logic [31:0] w;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(NW * 4));
      cs = 8'(NW * 4);
      for (int i = 0; i < NW; i++) begin
         w = mem[i];
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[8*b +: 8]);
            cs = cs ^ w[8*b +: 8];
         end
      end
      if (CS == 1) exp_q.push_back(cs);
   endtask

   task automatic cmp_frame(input string tag);
      int n;
      chk({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", tag, i), {24'h0, cap_q[i]}, {24'h0, exp_q[i]});
      cap_q.delete();
   endtask

   task automatic pulse_req();
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit rand_full);
      int waited = 0;
      while (done !== 1'b1 && waited < 2000) begin
         if (rand_full) txfifo_full = 1'($urandom_range(0, 1));
         tick();
         waited++;
      end
      txfifo_full = 1'b0;
      chk({tag, "_done_seen"}, {31'h0, done}, 32'h1);
   endtask

   initial begin
      int t0;
      int dc0;
      int guard;
      int exp_drop;

      // Reset state
      #3;
      chk("rst_busy", {31'h0, busy}, 0);
      chk("rst_done", {31'h0, done}, 0);
      chk("rst_word_rd", {31'h0, word_rd}, 0);
      chk("rst_txfifo_wr", {31'h0, txfifo_wr}, 0);
      chk("rst_word_addr", {31'h0, word_addr}, 0);
      chk("rst_txfifo_data", {24'h0, txfifo_data}, 0);
      chk("rst_dropped", {24'h0, dropped_cnt}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Basic frame and latency
      mem[0] = 32'h44332211;
      mem[1] = 32'h88776655;
      build_exp();
      dc0 = done_cnt;
      t0 = cyc;
      pulse_req();
      chk("c1_wr", {31'h0, txfifo_wr}, 1);
      chk("c1_sof", {24'h0, txfifo_data}, 32'hA5);
      chk("c1_busy", {31'h0, busy}, 1);
      tick();
      chk("c2_len", {24'h0, txfifo_data}, 32'h08);
      tick();
      chk("c3_word_rd", {31'h0, word_rd}, 1);
      chk("c3_word_addr", {31'h0, word_addr}, 0);
      wait_done("basic", 1'b0);
      chk("basic_done_cycle", 32'(cyc - t0), 32'(15 + CS));
      chk("basic_busy_at_done", {31'h0, busy}, 0);
      tick();
      chk("basic_done_pulse", {31'h0, done}, 0);
      chk("basic_done_count", 32'(done_cnt - dc0), 1);
      cmp_frame("basic");

      // Backpressure while 0x33 pending
      t0 = cyc;
      pulse_req();
      guard = 0;
      while (txfifo_data !== 8'h33 && guard < 50) begin
         tick();
         guard++;
      end
      chk("bp_found_33", {24'h0, txfifo_data}, 32'h33);
      txfifo_full = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("bp_no_wr", {31'h0, txfifo_wr}, 0);
         tick();
      end
      txfifo_full = 1'b0;
      chk("bp_still_33", {24'h0, txfifo_data}, 32'h33);
      wait_done("bp", 1'b0);
      chk("bp_done_cycle", 32'(cyc - t0), 32'(25 + CS));
      tick();
      cmp_frame("bp");

      // Three ignored requests during a frame
      dc0 = done_cnt;
      pulse_req();
      for (int i = 0; i < 3; i++) begin
         tick();
         pulse_req();
      end
      wait_done("drop3", 1'b0);
      tick();
      chk("drop3_cnt", {24'h0, dropped_cnt}, 3);
      chk("drop3_one_frame", 32'(done_cnt - dc0), 1);
      cmp_frame("drop3");

      // 300 ignored requests saturate the counter
      exp_drop = 3;
      txfifo_full = 1'b1;
      pulse_req();
      send_req = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (exp_drop < 255) exp_drop++;
      end
      send_req = 1'b0;
      chk("drop_sat", {24'h0, dropped_cnt}, 32'(exp_drop));
      txfifo_full = 1'b0;
      wait_done("drop_sat", 1'b0);
      tick();
      cmp_frame("drop_sat");

      // Reset while 0x66 is being emitted
      dc0 = done_cnt;
      pulse_req();
      guard = 0;
      while (!(txfifo_data === 8'h66 && txfifo_wr === 1'b1) && guard < 50) begin
         tick();
         guard++;
      end
      chk("rst_mid_found_66", {24'h0, txfifo_data}, 32'h66);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", {31'h0, busy}, 0);
      chk("rst_mid_wr", {31'h0, txfifo_wr}, 0);
      chk("rst_mid_data", {24'h0, txfifo_data}, 0);
      chk("rst_mid_word_addr", {31'h0, word_addr}, 0);
      chk("rst_mid_word_rd", {31'h0, word_rd}, 0);
      chk("rst_mid_dropped", {24'h0, dropped_cnt}, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_mid_no_done", 32'(done_cnt - dc0), 0);
      cap_q.delete();
      pulse_req();
      wait_done("after_rst", 1'b0);
      tick();
      cmp_frame("after_rst");

      // Request on the done cycle is accepted
      pulse_req();
      wait_done("b2b_first", 1'b0);
      pulse_req();
      chk("b2b_sof_wr", {31'h0, txfifo_wr}, 1);
      chk("b2b_sof", {24'h0, txfifo_data}, 32'hA5);
      wait_done("b2b_second", 1'b0);
      tick();
      chk("b2b_dropped", {24'h0, dropped_cnt}, 0);
      for (int i = 0; i < NW * 4 + 2 + CS; i++) exp_q.push_back(exp_q[i]);
      cmp_frame("b2b");

      // Random words with random backpressure
      for (int f = 0; f < 3; f++) begin
         mem[0] = $urandom;
         mem[1] = $urandom;
         build_exp();
         pulse_req();
         wait_done($sformatf("rand%0d", f), 1'b1);
         tick();
         cmp_frame($sformatf("rand%0d", f));
      end

      chk("wr_while_full", 32'(wr_full_viol), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
